// File: rtl/com_arbiter.sv
// rtl/com_arbiter.sv - round-robin arbiter sharing one command-write port
module com_arbiter #(
    parameter int NREQ = 2,
    parameter int DW   = 8,
    parameter int TMO  = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*DW-1:0]   cmd_in,
    input  logic                 halt,
    input  logic                 com_done,
    output logic [NREQ-1:0]      ack,
    output logic                 com_write,
    output logic [DW-1:0]        com_data,
    output logic [1:0]           grant_id,
    output logic                 busy,
    output logic                 timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        WRITE = 2'd2,
        WAIT  = 2'd3
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

    state_t          state;
    state_t          state_nxt;
    logic [7:0]      cnt;
    logic [3:0]      req_ext;
    logic            pick_valid;
    logic [1:0]      pick_id;
    logic [2:0]      cand;
    logic            grant_en;
    logic            tmo_hit;
    logic            com_write_d;
    logic            busy_d;
    logic            timeout_d;
    logic [NREQ-1:0] ack_d;

    assign req_ext  = 4'(req);
    assign grant_en = (state == IDLE) && !halt && pick_valid;
    // com_done has priority over an expiring counter on the same edge
    assign tmo_hit  = (state == WAIT) && !com_done && (cnt == TMO_LAST);

    // Round-robin pick: scan downward in offset so the nearest requester after grant_id wins
    always_comb begin
        pick_valid = 1'b0;
        pick_id    = grant_id;
        cand       = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = {1'b0, grant_id} + 3'(k);
            if (cand >= 3'(NREQ)) begin
                cand = cand - 3'(NREQ);
            end
            if (req_ext[cand[1:0]]) begin
                pick_valid = 1'b1;
                pick_id    = cand[1:0];
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_en) state_nxt = GRANT;
            GRANT:   state_nxt = WRITE;
            WRITE:   state_nxt = WAIT;
            WAIT:    if (com_done || tmo_hit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode, one cycle ahead so every output leaves a flop
    always_comb begin
        com_write_d = (state == GRANT);
        busy_d      = (state_nxt != IDLE);
        timeout_d   = tmo_hit;
        ack_d       = '0;
        for (int i = 0; i < NREQ; i++) begin
            ack_d[i] = com_write_d && (grant_id == 2'(i));
        end
    end

    // Registered outputs, grant latch and WAIT counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            com_write <= 1'b0;
            ack       <= '0;
            busy      <= 1'b0;
            timeout   <= 1'b0;
            com_data  <= '0;
            grant_id  <= 2'(NREQ - 1);
            cnt       <= '0;
        end else begin
            com_write <= com_write_d;
            ack       <= ack_d;
            busy      <= busy_d;
            timeout   <= timeout_d;
            if (grant_en) begin
                com_data <= cmd_in[int'(pick_id)*DW +: DW];
                grant_id <= pick_id;
            end
            if (state == WRITE) begin
                cnt <= '0;
            end else if (state == WAIT && state_nxt == WAIT) begin
                cnt <= cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_com_arbiter.sv
// tb/tb_com_arbiter.sv - self-checking bench for com_arbiter
module tb_com_arbiter;

    logic        clk;
    logic        reset;
    logic [1:0]  req;
    logic [15:0] cmd_in;
    logic        halt;
    logic        com_done;
    logic [1:0]  ack;
    logic        com_write;
    logic [7:0]  com_data;
    logic [1:0]  grant_id;
    logic        busy;
    logic        timeout;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [1:0] req;
        logic [7:0] c0;
        logic [7:0] c1;
        logic [1:0] exp_id;
        logic [7:0] exp_data;
        int         done_dly;
    } vec_t;

    typedef struct {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    vec_t vecs [6];
    exp_t sb [$];
    exp_t sb_e;
    logic [1:0] exp_ack;

    com_arbiter #(.NREQ(2), .DW(8), .TMO(255)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .cmd_in    (cmd_in),
        .halt      (halt),
        .com_done  (com_done),
        .ack       (ack),
        .com_write (com_write),
        .com_data  (com_data),
        .grant_id  (grant_id),
        .busy      (busy),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    task automatic push_exp(input logic [1:0] id, input logic [7:0] data);
        exp_t e;
        e.id   = id;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic wait_write(input int limit, output int cycles);
        cycles = 0;
        while (cycles < limit) begin
            @(negedge clk);
            cycles++;
            if (com_write) break;
        end
    endtask

    task automatic finish_cmd(input int dly);
        repeat (dly) @(negedge clk);
        com_done = 1'b1;
        @(negedge clk);
        com_done = 1'b0;
        check("done_busy_low", busy, 0);
    endtask

    // Scoreboard: every write strobe must match the oldest expected grant
    always @(negedge clk) begin
        if (reset && com_write) begin
            if (sb.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                sb_e    = sb.pop_front();
                exp_ack = 2'(1 << sb_e.id);
                check("sb_grant_id", grant_id, sb_e.id);
                check("sb_ack", ack, exp_ack);
                check("sb_com_data", com_data, sb_e.data);
                check("sb_busy", busy, 1);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int cyc;
        int k;
        int seen;
        int n_wr;

        vecs[0] = '{2'b01, 8'hA5, 8'h00, 2'd0, 8'hA5, 3};
        vecs[1] = '{2'b10, 8'h00, 8'h3C, 2'd1, 8'h3C, 1};
        vecs[2] = '{2'b11, 8'h11, 8'h22, 2'd0, 8'h11, 2};
        vecs[3] = '{2'b11, 8'h11, 8'h22, 2'd1, 8'h22, 1};
        vecs[4] = '{2'b10, 8'h00, 8'h5A, 2'd1, 8'h5A, 2};
        vecs[5] = '{2'b01, 8'hC3, 8'h00, 2'd0, 8'hC3, 3};

        reset = 1'b0; req = '0; cmd_in = '0; halt = 1'b0; com_done = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_com_write", com_write, 0);
        check("rst_ack", ack, 0);
        check("rst_busy", busy, 0);
        check("rst_timeout", timeout, 0);
        check("rst_com_data", com_data, 0);
        check("rst_grant_id", grant_id, 1);
        reset = 1'b1;
        @(negedge clk);
        check("idle_busy", busy, 0);

        // Table: single transactions, round-robin from the previous grant
        for (int i = 0; i < 6; i++) begin
            push_exp(vecs[i].exp_id, vecs[i].exp_data);
            req    = vecs[i].req;
            cmd_in = {vecs[i].c1, vecs[i].c0};
            wait_write(10, cyc);
            check("vec_latency", cyc, 2);
            req = '0;
            finish_cmd(vecs[i].done_dly);
            check("vec_data_held", com_data, vecs[i].exp_data);
        end

        // Contention: both held, grants must alternate
        req = 2'b11; cmd_in = {8'h77, 8'h66};
        push_exp(2'd1, 8'h77); push_exp(2'd0, 8'h66);
        push_exp(2'd1, 8'h77); push_exp(2'd0, 8'h66);
        for (int i = 0; i < 4; i++) begin
            wait_write(10, cyc);
            check("rr_latency", cyc, 2);
            if (i == 3) req = '0;
            finish_cmd(2);
        end

        // Timeout: no com_done, pulse 255 cycles after WAIT entry
        push_exp(2'd0, 8'h99);
        req = 2'b01; cmd_in = {8'h00, 8'h99};
        wait_write(10, cyc);
        check("tmo_latency", cyc, 2);
        req = '0;
        k = 0; seen = 0;
        while (k < 300 && seen == 0) begin
            @(negedge clk);
            k++;
            if (timeout) seen = 1;
        end
        check("tmo_cycles", k, 256);
        check("tmo_busy", busy, 0);
        @(negedge clk);
        check("tmo_one_cycle", timeout, 0);

        // Race: com_done on the expiring cycle wins
        push_exp(2'd0, 8'h42);
        req = 2'b01; cmd_in = {8'h00, 8'h42};
        wait_write(10, cyc);
        req = '0;
        seen = 0;
        for (int i = 0; i < 254; i++) begin
            @(negedge clk);
            if (timeout) seen++;
        end
        @(negedge clk);
        check("race_busy_before", busy, 1);
        com_done = 1'b1;
        @(negedge clk);
        com_done = 1'b0;
        check("race_no_timeout", timeout, 0);
        check("race_busy", busy, 0);
        check("race_early_timeouts", seen, 0);
        @(negedge clk);
        check("race_timeout_after", timeout, 0);

        // com_done during WRITE is ignored
        push_exp(2'd1, 8'hD7);
        req = 2'b10; cmd_in = {8'hD7, 8'h00};
        wait_write(10, cyc);
        req = '0;
        com_done = 1'b1;
        @(negedge clk);
        com_done = 1'b0;
        check("write_done_ignored", busy, 1);
        finish_cmd(1);

        // Halt blocks new grants only
        halt = 1'b1; req = 2'b10; cmd_in = {8'hE1, 8'h00};
        n_wr = 0;
        repeat (20) begin
            @(negedge clk);
            if (com_write) n_wr++;
        end
        check("halt_no_write", n_wr, 0);
        check("halt_busy", busy, 0);
        push_exp(2'd1, 8'hE1);
        halt = 1'b0;
        wait_write(10, cyc);
        check("halt_release_latency", cyc, 2);
        req = '0;
        halt = 1'b1;
        finish_cmd(3);
        req = 2'b01; cmd_in = {8'h00, 8'h3E};
        n_wr = 0;
        repeat (5) begin
            @(negedge clk);
            if (com_write) n_wr++;
        end
        check("halt_after_wait", n_wr, 0);
        push_exp(2'd0, 8'h3E);
        halt = 1'b0;
        wait_write(10, cyc);
        check("halt_second_latency", cyc, 2);
        req = '0;
        finish_cmd(1);

        // Asynchronous reset in the middle of WAIT
        push_exp(2'd1, 8'hB4);
        req = 2'b10; cmd_in = {8'hB4, 8'h00};
        wait_write(10, cyc);
        req = '0;
        repeat (3) @(negedge clk);
        check("pre_reset_busy", busy, 1);
        #2 reset = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_com_write", com_write, 0);
        check("arst_ack", ack, 0);
        check("arst_com_data", com_data, 0);
        check("arst_grant_id", grant_id, 1);
        @(negedge clk);
        reset = 1'b1;
        push_exp(2'd0, 8'h81);
        req = 2'b11; cmd_in = {8'h18, 8'h81};
        wait_write(10, cyc);
        check("post_reset_latency", cyc, 2);
        req = '0;
        finish_cmd(2);

        check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
